pwm_output_stage: RTL and testbench

//  Downstream consumer of the PWM counter. Compares count_val against double-buffered compare

---
 rtl/pwm_pkg.sv | 25 ++
 rtl/deadtime_inserter.sv | 78 +++++++
 rtl/pwm_output_stage.sv | 95 +++++++++
 tb/tb_pwm_output_stage.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_pkg
//  Description : Shared mode encodings and output-stage FSM state type for the
//                PWM output stage and its dead-time inserter.
//  Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    // Waveform alignment modes selected by the 'functions' input
    localparam logic [1:0] PWM_FUNC_LEFT  = 2'b00;
    localparam logic [1:0] PWM_FUNC_RIGHT = 2'b01;
    localparam logic [1:0] PWM_FUNC_RANGE = 2'b10;
    localparam logic [1:0] PWM_FUNC_RSVD  = 2'b11;

    // Output-stage states: both off, high side on, low side on, dead band
    typedef enum logic [1:0] {
        ST_OFF  = 2'b00,
        ST_ON_P = 2'b01,
        ST_ON_N = 2'b10,
        ST_DEAD = 2'b11
    } pwm_state_e;

endpackage
`default_nettype wire

// File: rtl/deadtime_inserter.sv
`default_nettype none
// ============================================================================
//  Module      : deadtime_inserter
//  Description : Turns a raw PWM level into a complementary output pair with a
//                programmable number of both-low cycles around every edge.
//                Pulses shorter than the dead time are swallowed.
//  Revision    : 1.0 - initial release
// ============================================================================
module deadtime_inserter
    import pwm_pkg::*;
#(
    parameter int DT_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            raw_i,
    input  logic            en_i,
    input  logic [DT_W-1:0] deadtime_i,
    output logic            out_p_o,
    output logic            out_n_o
);

    pwm_state_e      state_q;
    logic            target_q;
    logic [DT_W-1:0] dt_cnt_q;
    logic            out_p_q;
    logic            out_n_q;

    logic            dt_zero;
    logic            edge_start;

    assign dt_zero = (deadtime_i == '0);

    // A new edge begins when leaving OFF, when the raw level disagrees with
    // the side currently driven, or when it moves away from the pending target.
    assign edge_start = (state_q == ST_OFF)
                     || ((state_q == ST_ON_P) && !raw_i)
                     || ((state_q == ST_ON_N) &&  raw_i)
                     || ((state_q == ST_DEAD) && (raw_i != target_q));

    // Output FSM with registered outputs; the two sides are never driven together
    always_ff @(posedge clk) begin
        if (rst || !en_i) begin
            state_q  <= ST_OFF;
            target_q <= 1'b0;
            dt_cnt_q <= '0;
            out_p_q  <= 1'b0;
            out_n_q  <= 1'b0;
        end else if (edge_start) begin
            target_q <= raw_i;
            if (dt_zero) begin
                state_q  <= raw_i ? ST_ON_P : ST_ON_N;
                dt_cnt_q <= '0;
                out_p_q  <= raw_i;
                out_n_q  <= !raw_i;
            end else begin
                state_q  <= ST_DEAD;
                dt_cnt_q <= deadtime_i;
                out_p_q  <= 1'b0;
                out_n_q  <= 1'b0;
            end
        end else if (state_q == ST_DEAD) begin
            if (dt_cnt_q <= DT_W'(1)) begin
                state_q  <= target_q ? ST_ON_P : ST_ON_N;
                dt_cnt_q <= '0;
                out_p_q  <= target_q;
                out_n_q  <= !target_q;
            end else begin
                dt_cnt_q <= dt_cnt_q - DT_W'(1);
            end
        end
    end

    assign out_p_o = out_p_q;
    assign out_n_o = out_n_q;

endmodule
`default_nettype wire

// File: rtl/pwm_output_stage.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_output_stage
//  Description : Compares the counter value against double-buffered compare
//                values and drives a complementary PWM pair with dead time.
//                Shadow registers update only at the period boundary so duty
//                changes never disturb the period in progress.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_output_stage
    import pwm_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int DT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_en,
    input  logic [CNT_W-1:0] count_val,
    input  logic [CNT_W-1:0] period,
    input  logic             upnotdown,
    input  logic [CNT_W-1:0] compare1,
    input  logic [CNT_W-1:0] compare2,
    input  logic [1:0]       functions,
    input  logic [DT_W-1:0]  deadtime,
    output logic             pwm_out,
    output logic             pwm_out_n,
    output logic             cycle_start
);

    logic [CNT_W-1:0] prev_count_q;
    logic [CNT_W-1:0] cmp1_q;
    logic [CNT_W-1:0] cmp2_q;
    logic [1:0]       func_q;
    logic             cycle_start_q;

    logic             bnd;
    logic             shadow_load_d;
    logic             raw;

    // Boundary: counter arrives at its start value (0 up, period down); the
    // change test keeps a stalled counter from retriggering every cycle.
    assign bnd = (count_val == (upnotdown ? CNT_W'(0) : period))
              && (count_val != prev_count_q);

    // Shadows are transparent while disabled so the first enabled period
    // already uses the programmed values.
    assign shadow_load_d = !pwm_en || bnd;

    // Boundary history, compare/mode shadows and the cycle-start pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_count_q  <= '0;
            cmp1_q        <= '0;
            cmp2_q        <= '0;
            func_q        <= PWM_FUNC_LEFT;
            cycle_start_q <= 1'b0;
        end else begin
            prev_count_q  <= count_val;
            cycle_start_q <= pwm_en && bnd;
            if (shadow_load_d) begin
                cmp1_q <= compare1;
                cmp2_q <= compare2;
                func_q <= functions;
            end
        end
    end

    // Raw waveform from shadow values; range mode with an empty window is low
    always_comb begin
        raw = 1'b0;
        case (func_q)
            PWM_FUNC_LEFT:  raw = (count_val <  cmp1_q);
            PWM_FUNC_RIGHT: raw = (count_val >= cmp1_q);
            PWM_FUNC_RANGE: raw = (cmp1_q <= count_val) && (count_val < cmp2_q);
            default:        raw = 1'b0;
        endcase
    end

    deadtime_inserter #(
        .DT_W (DT_W)
    ) u_deadtime (
        .clk        (clk),
        .rst        (rst),
        .raw_i      (raw),
        .en_i       (pwm_en),
        .deadtime_i (deadtime),
        .out_p_o    (pwm_out),
        .out_n_o    (pwm_out_n)
    );

    assign cycle_start = cycle_start_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_output_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_output_stage
//  Description : Self-checking bench for pwm_output_stage. A cycle model feeds
//                a scoreboard queue; a vector table checks per-period duty.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_output_stage;

    localparam int S_OFF  = 0;
    localparam int S_ONP  = 1;
    localparam int S_ONN  = 2;
    localparam int S_DEAD = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        pwm_en;
    logic [15:0] count_val;
    logic [15:0] period;
    logic        upnotdown;
    logic [15:0] compare1;
    logic [15:0] compare2;
    logic [1:0]  functions;
    logic [7:0]  deadtime;
    logic        pwm_out;
    logic        pwm_out_n;
    logic        cycle_start;

    int checks = 0;
    int passes = 0;

    typedef struct packed {
        logic p;
        logic n;
        logic cs;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic        up;
        logic [1:0]  f;
        logic [15:0] c1;
        logic [15:0] c2;
        logic [7:0]  dt;
        int          exp_p;
        int          exp_n;
    } vec_t;
    vec_t vecs[10];

    // reference model state
    logic [15:0] m_prev, m_c1, m_c2;
    logic [1:0]  m_f;
    int          m_st, m_dt;
    logic        m_tgt, m_cs;
    int          cnt;

    pwm_output_stage #(.CNT_W(16), .DT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .pwm_en      (pwm_en),
        .count_val   (count_val),
        .period      (period),
        .upnotdown   (upnotdown),
        .compare1    (compare1),
        .compare2    (compare2),
        .functions   (functions),
        .deadtime    (deadtime),
        .pwm_out     (pwm_out),
        .pwm_out_n   (pwm_out_n),
        .cycle_start (cycle_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    function automatic logic m_raw(input logic [15:0] c);
        case (m_f)
            2'b00:   return c < m_c1;
            2'b01:   return c >= m_c1;
            2'b10:   return (c >= m_c1) && (c < m_c2);
            default: return 1'b0;
        endcase
    endfunction

    // advance the model by one clock using the inputs currently driven
    task automatic model_step();
        logic bnd, raw;
        bnd = (count_val == (upnotdown ? 16'd0 : period)) && (count_val != m_prev);
        raw = m_raw(count_val);
        if (rst) begin
            m_prev = 0; m_c1 = 0; m_c2 = 0; m_f = 0;
            m_st = S_OFF; m_tgt = 0; m_dt = 0; m_cs = 0;
        end else begin
            m_cs = pwm_en && bnd;
            if (!pwm_en || bnd) begin
                m_c1 = compare1; m_c2 = compare2; m_f = functions;
            end
            m_prev = count_val;
            if (!pwm_en) begin
                m_st = S_OFF; m_dt = 0;
            end else begin
                case (m_st)
                    S_OFF: begin
                        m_tgt = raw;
                        if (deadtime == 0) m_st = raw ? S_ONP : S_ONN;
                        else begin m_st = S_DEAD; m_dt = int'(deadtime); end
                    end
                    S_ONP: if (!raw) begin
                        m_tgt = 0;
                        if (deadtime == 0) m_st = S_ONN;
                        else begin m_st = S_DEAD; m_dt = int'(deadtime); end
                    end
                    S_ONN: if (raw) begin
                        m_tgt = 1;
                        if (deadtime == 0) m_st = S_ONP;
                        else begin m_st = S_DEAD; m_dt = int'(deadtime); end
                    end
                    default: begin
                        if (raw != m_tgt) begin
                            m_tgt = raw;
                            if (deadtime == 0) m_st = raw ? S_ONP : S_ONN;
                            else m_dt = int'(deadtime);
                        end else if (m_dt == 1) begin
                            m_st = m_tgt ? S_ONP : S_ONN;
                            m_dt = 0;
                        end else begin
                            m_dt = m_dt - 1;
                        end
                    end
                endcase
            end
        end
    endtask

    task automatic tick();
        exp_t e;
        model_step();
        e.p  = (m_st == S_ONP);
        e.n  = (m_st == S_ONN);
        e.cs = m_cs;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            checks++;
            $display("FAIL scoreboard: got empty queue, expected an entry");
        end else begin
            e = sb_q.pop_front();
            check("scoreboard", 32'({pwm_out, pwm_out_n, cycle_start}), 32'({e.p, e.n, e.cs}));
        end
        check("no_overlap", 32'(pwm_out & pwm_out_n), 32'd0);
    endtask

    // drive the bench counter value, clock once, then advance the counter
    task automatic step();
        count_val = cnt[15:0];
        tick();
        if (upnotdown) cnt = (cnt >= int'(period)) ? 0 : cnt + 1;
        else           cnt = (cnt == 0) ? int'(period) : cnt - 1;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic configure(input vec_t v);
        pwm_en    = 1'b0;
        period    = 16'd9;
        upnotdown = v.up;
        functions = v.f;
        compare1  = v.c1;
        compare2  = v.c2;
        deadtime  = v.dt;
        cnt       = v.up ? 0 : 9;
        run(2);
        pwm_en = 1'b1;
        run(30);
    endtask

    task automatic align_to(input int target);
        int guard;
        guard = 0;
        while (cnt != target && guard < 40) begin
            step();
            guard++;
        end
        if (cnt != target) check("align_timeout", 32'(cnt), 32'(target));
    endtask

    initial begin
        int sp, sn, scs, guard;
        vec_t v;

        // up/down, mode, cmp1, cmp2, deadtime, high-side clks, low-side clks per 10-clk period
        vecs[0] = '{1'b1, 2'b00, 16'd4,  16'd0, 8'd0, 4,  6};
        vecs[1] = '{1'b1, 2'b00, 16'd4,  16'd0, 8'd2, 2,  4};
        vecs[2] = '{1'b1, 2'b10, 16'd3,  16'd6, 8'd0, 3,  7};
        vecs[3] = '{1'b1, 2'b10, 16'd6,  16'd3, 8'd0, 0,  10};
        vecs[4] = '{1'b1, 2'b11, 16'd3,  16'd6, 8'd0, 0,  10};
        vecs[5] = '{1'b0, 2'b10, 16'd3,  16'd6, 8'd0, 3,  7};
        vecs[6] = '{1'b1, 2'b00, 16'd0,  16'd0, 8'd0, 0,  10};
        vecs[7] = '{1'b1, 2'b00, 16'd10, 16'd0, 8'd0, 10, 0};
        vecs[8] = '{1'b1, 2'b01, 16'd4,  16'd0, 8'd0, 6,  4};
        vecs[9] = '{1'b1, 2'b00, 16'd2,  16'd0, 8'd3, 0,  5};

        rst = 1'b1; pwm_en = 1'b0; count_val = 16'd0; period = 16'd9;
        upnotdown = 1'b1; compare1 = 16'd4; compare2 = 16'd0;
        functions = 2'b00; deadtime = 8'd0; cnt = 0;
        m_prev = 0; m_c1 = 0; m_c2 = 0; m_f = 0; m_st = S_OFF; m_dt = 0; m_tgt = 0; m_cs = 0;

        // reset with enable requested: everything must stay low
        pwm_en = 1'b1;
        run(3);
        check("reset_outputs", 32'({pwm_out, pwm_out_n, cycle_start}), 32'd0);
        rst = 1'b0;

        // per-period duty, complement width and one cycle_start per period
        for (int i = 0; i < 10; i++) begin
            v = vecs[i];
            configure(v);
            sp = 0; sn = 0; scs = 0;
            for (int k = 0; k < 10; k++) begin
                step();
                sp  += int'(pwm_out);
                sn  += int'(pwm_out_n);
                scs += int'(cycle_start);
            end
            check($sformatf("vec%0d_high", i), 32'(sp), 32'(v.exp_p));
            check($sformatf("vec%0d_low", i), 32'(sn), 32'(v.exp_n));
            check($sformatf("vec%0d_cycle_start", i), 32'(scs), 32'd1);
        end

        // shadowing: compare rewrite mid-period only takes effect next period
        configure(vecs[0]);
        align_to(0);
        sp = 0;
        for (int k = 0; k < 10; k++) begin
            if (k == 2) compare1 = 16'd7;
            step();
            sp += int'(pwm_out);
        end
        check("shadow_current_period", 32'(sp), 32'd4);
        sp = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            sp += int'(pwm_out);
        end
        check("shadow_next_period", 32'(sp), 32'd7);

        // reset in the middle of a dead band, then dead time on re-entry
        v = vecs[0];
        v.dt = 8'd3;
        configure(v);
        pwm_en = 1'b0;
        align_to(1);
        pwm_en = 1'b1;
        run(2);
        rst = 1'b1;
        step();
        check("rst_mid_dead", 32'({pwm_out, pwm_out_n}), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("rst_reentry_dead", 32'({pwm_out, pwm_out_n}), 32'd0);
        end
        step();
        check("rst_reentry_active", 32'({pwm_out, pwm_out_n}), 32'b01);

        // disable while the high side is on, then re-enable
        configure(v);
        guard = 0;
        while (pwm_out !== 1'b1 && guard < 40) begin
            step();
            guard++;
        end
        check("wait_on_p", 32'(pwm_out), 32'd1);
        pwm_en = 1'b0;
        step();
        check("disable_mid_on_p", 32'({pwm_out, pwm_out_n}), 32'd0);
        pwm_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("reenable_dead", 32'({pwm_out, pwm_out_n}), 32'd0);
        end
        step();
        check("reenable_active", 32'({pwm_out, pwm_out_n}), 32'b01);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
